vector_result_writeback: RTL and testbench
==========================================

# vector_result_writeback

Downstream stage of the vector function unit. It captures the finished result vector when the unit reports `VEC_ALU_FINISHED`, and merges it element by element with the old destination register contents. Masked-off and tail elements are handled during the merge. The merged register is then written to the vector register file through a request/acknowledge handshake.

## Interface
- `LEN`, 32, scalar int width; VLEN = VECTOR_SIZE*LEN
- `VECTOR_SIZE`, 8, number of LEN-wide words in a vector register
- `ENTRY_INDEX_SIZE`, 3, element count port is ENTRY_INDEX_SIZE+1 bits
- `LANE_SIZE`, 2, elements merged per cycle
- `clk` in 1: the single clock; all state on its rising edge
- `rst` in 1: reset, asynchronous and active-low
- `rdy_in` in 1: global enable; low freezes MERGE/WRITE progress
- `alu_status` in 2: function unit status (`VEC_ALU_NOP`/`WORKING`/`FINISHED`)
- `alu_result` in VLEN: function unit result vector
- `vsew` in 3: element width (`ONE_BYTE`/`TWO_BYTE`/`FOUR_BYTE`/`EIGHT_BYTE`)
- `vm` in 1: 1 = unmasked, 0 = masked by `mask`
- `mask` in VLEN: bit i enables element i
- `length` in ENTRY_INDEX_SIZE+1: active element count
- `old_vd` in VLEN: current destination register contents
- `vd_addr` in 5: destination register index
- `vrf_write_ack` in 1: register file accepted the write
- `vrf_write_en` out 1: write request
- `vrf_write_addr` out 5: register index
- `vrf_write_data` out VLEN: merged vector
- `wb_busy` out 1: a job is held; upstream must not finish a new job
- `wb_done` out 1: one-cycle pulse per completed write
- `overrun` out 1: sticky; FINISHED arrived while busy

## Operation
- The states are IDLE, MERGE and WRITE.
- **Capture in IDLE.** When `alu_status==VEC_ALU_FINISHED`, capture occurs regardless of `rdy_in`. The block latches:
  - `alu_result`, `old_vd`, `mask`, `vm`, `vsew`, `length` and `vd_addr`;
  - the element index is cleared to 0;
  - the merge buffer is initialised per the tail policy (see Configuration).
  - Next state is MERGE, or WRITE if `length==0`.
- **MERGE.** Each cycle with `rdy_in` high processes elements idx..idx+LANE_SIZE-1.
  - Only elements with index < `length` are processed, and only if index < VLEN/SEW.
  - SEW is 8/16/32/64 bits.
  - The buffer element takes the result element if `vm==1` or `mask[i]==1`; otherwise it takes the `old_vd` element (mask undisturbed).
  - idx advances by LANE_SIZE.
  - When idx+LANE_SIZE ≥ `length`, the state moves to WRITE after that cycle.
  - Elements with index ≥ VLEN/SEW are ignored, with no wrap-around.
- **WRITE.** `vrf_write_en`=1 and `vrf_write_addr`/`vrf_write_data` are held stable until `vrf_write_ack` is sampled high with `rdy_in` high.
  - On that edge: `vrf_write_en`←0, `wb_done`←1 for one cycle, next state IDLE.
- **Overrun.** FINISHED seen in MERGE or WRITE sets `overrun`, which is cleared only by reset. The new job is dropped and the current job continues unaffected.
- **Flags.** `wb_busy` = (state != IDLE).
- **Reset.** Reset asserted at any time returns to IDLE, discards any held job, and clears all outputs:
  - `vrf_write_en`=0, `vrf_write_addr`=0, `vrf_write_data`=0;
  - `wb_busy`=0, `wb_done`=0, `overrun`=0.

## Timing
- Capture edge C.
- MERGE occupies edges C+1..C+k, where k = ceil(`length`/LANE_SIZE) plus any cycles with `rdy_in` low. For `length==0`, k=0.
- `vrf_write_en` rises after edge C+k and is high from cycle C+k+1.
- With an ack already high, write completes on edge C+k+1.
- `wb_done` is high for the cycle following the ack edge; `wb_busy` is low in that same cycle.
- A back-to-back FINISHED is accepted in the same cycle `wb_done` is high, since the state is IDLE.
- Ack while `rdy_in` is low is ignored; the request stays held.

## Configuration
- `VECTOR_WB_TAIL_AGNOSTIC_EN` defined: at capture the merge buffer is filled with all ones, so tail elements (index ≥ `length`) are written as all ones.
- Undefined: the merge buffer is initialised from `old_vd`, so tail elements are undisturbed.
- Masked-off body elements always take `old_vd` in both cases.

## Test plan
- **Unmasked full write.** SEW=32, `length`=8, `vm`=1, result element i = 100+i, `old_vd` all 0xAAAAAAAA, ack tied high → data elements 100..107, `vrf_write_en` high at C+5, `wb_done` at C+6.
- **Masked partial write.** SEW=32, `length`=6, `vm`=0, `mask`=0b00001010 → elements 1 and 3 from result, elements 0, 2, 4 and 5 from old. Elements 6–7 are 0xAAAAAAAA with the macro off and 0xFFFFFFFF with it on.
- **Byte elements.** SEW=8, `length`=15 → 8 MERGE cycles; bytes 0–14 from result, bytes 15–31 tail per macro. `length`=0 → write at C+1 with the tail-only buffer.
- **Delayed ack and overrun.** Ack delayed 3 cycles → `vrf_write_en` high for 4 cycles with stable data. A FINISHED inside that window sets `overrun`=1 with no second write.
- **Stall.** `rdy_in` low for 2 cycles mid-MERGE (SEW=32, `length`=8) → `vrf_write_en` at C+7. FINISHED with `rdy_in` low in IDLE is still captured.
- **Reset mid-operation.** `rst` low during MERGE → all outputs 0 immediately. After release, the next FINISHED job completes normally and `overrun` stays 0.

Source files
------------

// File: rtl/vector_result_writeback.sv
// Captures a finished vector result, merges it with the old destination under mask/length, then writes it back.
// Optional macro VECTOR_WB_TAIL_AGNOSTIC_EN: tail elements are written as all ones instead of left undisturbed.
module vector_result_writeback #(
  parameter int LEN              = 32,
  parameter int VECTOR_SIZE      = 8,
  parameter int ENTRY_INDEX_SIZE = 3,
  parameter int LANE_SIZE        = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rdy_in,
  input  logic [1:0]                    alu_status,
  input  logic [VECTOR_SIZE*LEN-1:0]    alu_result,
  input  logic [2:0]                    vsew,
  input  logic                          vm,
  input  logic [VECTOR_SIZE*LEN-1:0]    mask,
  input  logic [ENTRY_INDEX_SIZE:0]     length,
  input  logic [VECTOR_SIZE*LEN-1:0]    old_vd,
  input  logic [4:0]                    vd_addr,
  input  logic                          vrf_write_ack,
  output logic                          vrf_write_en,
  output logic [4:0]                    vrf_write_addr,
  output logic [VECTOR_SIZE*LEN-1:0]    vrf_write_data,
  output logic                          wb_busy,
  output logic                          wb_done,
  output logic                          overrun
);
  localparam int VLEN   = VECTOR_SIZE * LEN;
  localparam int NBYTES = VLEN / 8;
  localparam int EW     = $clog2(NBYTES);
  localparam int IDXW   = ENTRY_INDEX_SIZE + 2;
  localparam int CW     = ((EW > IDXW) ? EW : IDXW) + 1;

  // Function unit status encoding: NOP=0, WORKING=1, FINISHED=2.
  localparam logic [1:0] VEC_ALU_FINISHED = 2'd2;

  typedef enum logic [1:0] {IDLE, MERGE, WRITE} state_t;

  state_t                  state;
  logic [VLEN-1:0]         result_reg;
  logic [VLEN-1:0]         old_reg;
  logic [NBYTES-1:0]       mask_reg;
  logic                    vm_reg;
  logic [1:0]              shift_reg;
  logic [ENTRY_INDEX_SIZE:0] length_reg;
  logic [IDXW-1:0]         idx_reg;
  logic [VLEN-1:0]         data_reg;
  logic [4:0]              addr_reg;
  logic                    we_reg;
  logic                    done_reg;
  logic                    over_reg;

  logic [VLEN-1:0]         merged;
  logic                    last_beat;
  logic                    finished;
  logic                    unused_mask;

  assign finished    = (alu_status == VEC_ALU_FINISHED);
  assign last_beat   = (CW'(idx_reg) + CW'(LANE_SIZE)) >= CW'(length_reg);
  assign unused_mask = ^mask[VLEN-1:NBYTES];

  // Each byte belongs to element (byte >> log2(SEW bytes)); bytes of elements in the current lane window get merged.
  genvar gi;
  generate
    for (gi = 0; gi < NBYTES; gi++) begin : g_byte
      logic [EW-1:0] elem;
      logic          in_lane;
      logic          take_result;
      assign elem        = EW'(gi) >> shift_reg;
      assign in_lane     = (CW'(elem) >= CW'(idx_reg)) &&
                           (CW'(elem) <  CW'(idx_reg) + CW'(LANE_SIZE)) &&
                           (CW'(elem) <  CW'(length_reg));
      assign take_result = vm_reg | mask_reg[elem];
      assign merged[gi*8 +: 8] = !in_lane    ? data_reg[gi*8 +: 8]   :
                                 take_result ? result_reg[gi*8 +: 8] :
                                               old_reg[gi*8 +: 8];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      result_reg <= '0;
      old_reg    <= '0;
      mask_reg   <= '0;
      vm_reg     <= 1'b0;
      shift_reg  <= '0;
      length_reg <= '0;
      idx_reg    <= '0;
      data_reg   <= '0;
      addr_reg   <= '0;
      we_reg     <= 1'b0;
      done_reg   <= 1'b0;
      over_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state)
        IDLE: begin
          if (finished) begin
            result_reg <= alu_result;
            old_reg    <= old_vd;
            mask_reg   <= mask[NBYTES-1:0];
            vm_reg     <= vm;
            // Reserved width encodings are treated as the widest element.
            shift_reg  <= vsew[2] ? 2'd3 : vsew[1:0];
            length_reg <= length;
            idx_reg    <= '0;
            addr_reg   <= vd_addr;
`ifdef VECTOR_WB_TAIL_AGNOSTIC_EN
            data_reg   <= '1;
`else
            data_reg   <= old_vd;
`endif
            if (length == '0) begin
              state  <= WRITE;
              we_reg <= 1'b1;
            end else begin
              state  <= MERGE;
            end
          end
        end
        MERGE: begin
          if (finished) over_reg <= 1'b1;
          if (rdy_in) begin
            data_reg <= merged;
            idx_reg  <= idx_reg + IDXW'(LANE_SIZE);
            if (last_beat) begin
              state  <= WRITE;
              we_reg <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (finished) over_reg <= 1'b1;
          if (rdy_in && vrf_write_ack) begin
            we_reg   <= 1'b0;
            done_reg <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign vrf_write_en   = we_reg;
  assign vrf_write_addr = addr_reg;
  assign vrf_write_data = data_reg;
  assign wb_busy        = (state != IDLE);
  assign wb_done        = done_reg;
  assign overrun        = over_reg;
endmodule

// File: tb/tb_vector_result_writeback.sv
// Testbench for vector_result_writeback: directed literal cases plus randomized traffic against a behavioural model.
module tb_vector_result_writeback;
  localparam int VLEN = 256;
  localparam int LANE = 2;
  localparam logic [1:0] NOP = 2'd0, FIN = 2'd2;
`ifdef VECTOR_WB_TAIL_AGNOSTIC_EN
  localparam logic [31:0] TAIL32 = 32'hFFFFFFFF;
  localparam bit TAIL_ONES = 1'b1;
`else
  localparam logic [31:0] TAIL32 = 32'hAAAAAAAA;
  localparam bit TAIL_ONES = 1'b0;
`endif
  localparam logic [VLEN-1:0] OLD_A = {8{32'hAAAAAAAA}};
  localparam logic [VLEN-1:0] RES_W = 256'h0000006b_0000006a_00000069_00000068_00000067_00000066_00000065_00000064;

  logic clk, rst, rdy_in, vm, vrf_write_ack;
  logic [1:0] alu_status;
  logic [VLEN-1:0] alu_result, mask, old_vd, vrf_write_data;
  logic [2:0] vsew;
  logic [3:0] length;
  logic [4:0] vd_addr, vrf_write_addr;
  logic vrf_write_en, wb_busy, wb_done, overrun;

  int errors = 0;
  int checks = 0;

  vector_result_writeback dut (
    .clk(clk), .rst(rst), .rdy_in(rdy_in), .alu_status(alu_status), .alu_result(alu_result),
    .vsew(vsew), .vm(vm), .mask(mask), .length(length), .old_vd(old_vd), .vd_addr(vd_addr),
    .vrf_write_ack(vrf_write_ack), .vrf_write_en(vrf_write_en), .vrf_write_addr(vrf_write_addr),
    .vrf_write_data(vrf_write_data), .wb_busy(wb_busy), .wb_done(wb_done), .overrun(overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [VLEN+7:0] act, input logic [VLEN+7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural model: expected merged vector straight from the element rules.
  function automatic logic [VLEN-1:0] exp_data(input logic [VLEN-1:0] res, input logic [VLEN-1:0] old,
                                               input logic [VLEN-1:0] msk, input logic v,
                                               input logic [2:0] sew, input logic [3:0] len);
    logic [VLEN-1:0] d;
    int sew_bits;
    sew_bits = 8 << sew;
    for (int i = 0; i < VLEN; i++) begin
      int e;
      e = i / sew_bits;
      if (e < int'(len)) d[i] = (v || msk[e]) ? res[i] : old[i];
      else               d[i] = TAIL_ONES ? 1'b1 : old[i];
    end
    return d;
  endfunction

  logic m_busy, m_we, m_done, m_over;
  logic [4:0] m_addr;
  logic [VLEN-1:0] m_data;
  int m_rem;

  task automatic model_reset();
    m_busy = 0; m_we = 0; m_done = 0; m_over = 0; m_addr = '0; m_data = '0; m_rem = 0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (!rst) model_reset();
      else begin
        m_done = 0;
        if (!m_busy) begin
          if (alu_status == FIN) begin
            m_data = exp_data(alu_result, old_vd, mask, vm, vsew, length);
            m_addr = vd_addr;
            m_rem  = (int'(length) + LANE - 1) / LANE;
            m_busy = 1;
            m_we   = (m_rem == 0);
          end
        end else begin
          if (alu_status == FIN) m_over = 1;
          if (m_rem > 0) begin
            if (rdy_in) begin
              m_rem--;
              if (m_rem == 0) m_we = 1;
            end
          end else if (rdy_in && vrf_write_ack) begin
            m_we = 0; m_busy = 0; m_done = 1;
          end
        end
      end
    end
  end

  initial forever begin
    @(negedge rst);
    model_reset();
  end

  // Per-cycle compare of DUT outputs against the model.
  initial forever begin
    @(negedge clk);
    check("flags", {vrf_write_en, wb_busy, wb_done, overrun}, {m_we, m_busy, m_done, m_over});
    if (m_we) check("write", {vrf_write_addr, vrf_write_data}, {m_addr, m_data});
  end

  task automatic run_job(input logic [VLEN-1:0] res, input logic [VLEN-1:0] old, input logic [VLEN-1:0] msk,
                         input logic v, input logic [2:0] sew, input logic [3:0] len, input logic [4:0] addr,
                         input bit stall, input int ack_delay, input bit inject,
                         output int n_we, output int n_done, output int we_cycles, output logic [VLEN-1:0] seen);
    n_we = -1; n_done = -1; we_cycles = 0; seen = '0;
    @(negedge clk);
    alu_result = res; old_vd = old; mask = msk; vm = v; vsew = sew; length = len; vd_addr = addr;
    alu_status = FIN; rdy_in = !stall; vrf_write_ack = 0;
    @(negedge clk);
    alu_status = NOP; rdy_in = 1;
    for (int n = 0; n < 60; n++) begin
      if (stall) rdy_in = !(n == 1 || n == 2);
      if (vrf_write_en) begin
        we_cycles++;
        if (n_we < 0) begin n_we = n; seen = vrf_write_data; end
      end
      if (wb_done) begin n_done = n; break; end
      vrf_write_ack = (we_cycles > ack_delay);
      alu_status = (inject && we_cycles == 2) ? FIN : NOP;
      @(negedge clk);
    end
    alu_status = NOP; vrf_write_ack = 0; rdy_in = 1;
    check("job_completes", {7'd0, n_done >= 0}, 1);
  endtask

  initial begin
    int nw, nd, wc;
    logic [VLEN-1:0] seen;
    rst = 0; rdy_in = 1; alu_status = NOP; alu_result = '0; vsew = 3'd2; vm = 1;
    mask = '0; length = '0; old_vd = '0; vd_addr = '0; vrf_write_ack = 0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {vrf_write_en, vrf_write_addr, vrf_write_data, wb_busy, wb_done, overrun}, '0);
    rst = 1;

    run_job(RES_W, OLD_A, '0, 1, 3'd2, 4'd8, 5'd3, 0, 0, 0, nw, nd, wc, seen);
    check("full_we_edge", nw, 4);
    check("full_done_edge", nd, 5);
    check("full_data", seen, RES_W);

    run_job(RES_W, OLD_A, 256'b1010, 0, 3'd2, 4'd6, 5'd7, 0, 0, 0, nw, nd, wc, seen);
    check("masked_data", seen, {TAIL32, TAIL32, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'h00000067,
                                32'hAAAAAAAA, 32'h00000065, 32'hAAAAAAAA});

    run_job(RES_W, OLD_A, '0, 1, 3'd0, 4'd15, 5'd9, 0, 0, 0, nw, nd, wc, seen);
    check("byte_we_edge", nw, 8);
    check("byte_data", seen, {TAIL32, TAIL32, TAIL32, TAIL32, TAIL32[31:24], 24'h000067,
                              32'h00000066, 32'h00000065, 32'h00000064});

    run_job(RES_W, OLD_A, '0, 1, 3'd2, 4'd0, 5'd1, 0, 0, 0, nw, nd, wc, seen);
    check("len0_we_edge", nw, 0);
    check("len0_data", seen, {8{TAIL32}});

    run_job(RES_W, OLD_A, '0, 1, 3'd2, 4'd8, 5'd4, 1, 0, 0, nw, nd, wc, seen);
    check("stall_we_edge", nw, 6);
    check("stall_data", seen, RES_W);

    run_job(RES_W, OLD_A, '0, 1, 3'd2, 4'd8, 5'd5, 0, 3, 1, nw, nd, wc, seen);
    check("delayed_we_cycles", wc, 4);
    repeat (3) @(negedge clk);
    check("overrun_no_rewrite", {vrf_write_en, wb_busy, overrun}, 3'b001);

    // Reset in the middle of MERGE.
    @(negedge clk);
    alu_result = RES_W; old_vd = OLD_A; vm = 1; vsew = 3'd2; length = 4'd8; vd_addr = 5'd6; alu_status = FIN;
    @(negedge clk);
    alu_status = NOP;
    @(negedge clk);
    #2 rst = 0;
    #1 check("reset_mid_merge", {vrf_write_en, vrf_write_addr, vrf_write_data, wb_busy, wb_done, overrun}, '0);
    @(negedge clk);
    rst = 1;
    run_job(RES_W, OLD_A, '0, 1, 3'd2, 4'd8, 5'd6, 0, 0, 0, nw, nd, wc, seen);
    check("post_reset_data", seen, RES_W);
    check("post_reset_overrun", overrun, 0);

    // Randomized traffic: the per-cycle compare process does the checking.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int w = 0; w < 8; w++) begin
        alu_result[w*32 +: 32] = $urandom;
        old_vd[w*32 +: 32]     = $urandom;
        mask[w*32 +: 32]       = $urandom;
      end
      vm = 1'($urandom_range(0, 1));
      vsew = 3'($urandom_range(0, 3));
      length = 4'($urandom_range(0, 15));
      vd_addr = 5'($urandom);
      rdy_in = ($urandom_range(0, 3) != 0);
      vrf_write_ack = ($urandom_range(0, 2) != 0);
      alu_status = ($urandom_range(0, 5) == 0) ? FIN : 2'($urandom_range(0, 1));
    end
    @(negedge clk);
    alu_status = NOP; rdy_in = 1; vrf_write_ack = 1;
    repeat (20) @(negedge clk);
    check("drain_idle", {vrf_write_en, wb_busy}, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
